lo_ssp_tx: RTL and testbench
============================

// Module: lo_ssp_tx
// PURPOSE
// - FPGA->ARM SSP sample transmitter: the return path of the ARM->FPGA configuration link.
// - LF mode logic (lo_read, lo_edge_detect) pushes 8-bit samples into a small FIFO.
// - Each sample is serialised MSB-first on ssp_clk/ssp_frame/ssp_din for the ARM's SSP receiver.
// - The block is instantiated once in fpga_lf; its ssp_* outputs feed the major-mode muxes.
// PARAMETERS
// - CLK_DIV     4  pck0 cycles per ssp_clk half-period (>=1); bit period = 2*CLK_DIV pck0 cycles.
// - FIFO_DEPTH  4  sample FIFO entries; must be a power of 2.
// PORTS
// - pck0          in   1  LF system clock; all logic is rising-edge.
// - rst           in   1  reset: synchronous, active-high.
// - en            in   1  transmitter enable (driven by the major-mode decode).
// - sample_in     in   8  sample data.
// - sample_valid  in   1  sample present this cycle.
// - sample_ready  out  1  FIFO not full; a push occurs when valid && ready.
// - ssp_clk       out  1  serial clock to the ARM; the ARM samples ssp_din on the rising edge.
// - ssp_frame     out  1  high during the first (MSB) bit period of each word.
// - ssp_din       out  1  serial data, MSB first.
// - busy          out  1  shifter active (state != IDLE).
// - overrun       out  1  sticky: set when a sample was dropped while the FIFO was full.
// BEHAVIOUR
// - Reset values: ssp_clk=0, ssp_frame=0, ssp_din=0, busy=0, overrun=0, sample_ready=1.
//   - Reset also empties the FIFO and clears the divider and bit counter.
//   - Reset mid-word aborts the word at once; outputs take reset values on the next edge.
// - FIFO:
//   - sample_ready = !full, registered from the occupancy count.
//   - Push and pop in the same cycle are legal when not full; occupancy is then unchanged.
//   - valid && !ready: sample dropped, overrun<=1.
//   - overrun is cleared only by rst or by en==0.
// - FSM IDLE -> LOAD -> SHIFT:
//   - IDLE: ssp_clk/ssp_frame/ssp_din held 0.
//     - If en && FIFO not empty: pop the head into shift_reg[7:0] and go to LOAD.
//   - LOAD (1 cycle): div_cnt<=0, bit_cnt<=NBITS-1.
//     - Drive ssp_din<=shift_reg[MSB], ssp_frame<=1, ssp_clk<=0.
//     - Go to SHIFT.
//   - SHIFT: div_cnt counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and ssp_clk toggles.
//     - On each falling toggle (1->0), ssp_frame<=0 and the next bit is shifted onto ssp_din.
//     - On the falling toggle after the last bit (bit_cnt==0):
//       - If en && FIFO not empty: pop and load directly, with no extra cycle.
//       - The first bit of that word is on ssp_din and ssp_frame=1 in the same cycle.
//       - Otherwise go to IDLE.
// - Latency: push (cycle 0) -> LOAD (cycle 2) -> ssp_frame=1 (cycle 3).
//   - First ssp_clk rise at cycle 3+CLK_DIV.
// - NBITS = 8 without the macro, 9 with it. Word time = 2*CLK_DIV*NBITS pck0 cycles.
// - en falls mid-word: the current word completes; then IDLE and the FIFO is flushed.
//   - Pushes are ignored while en==0; this is not an overrun.
// CONFIGURATION
// - `define SSP_TX_PARITY_EN:
//   - Append an even-parity bit (XOR of the 8 data bits) after the LSB; NBITS=9.
//   - ssp_frame timing is unchanged.
// - Not defined: NBITS=8; data bits only.
// TESTING
// - Single word: CLK_DIV=2, push 0xA5.
//   - ssp_frame high exactly 4 cycles.
//   - ssp_din on rising edges reads 1,0,1,0,0,1,0,1.
//   - 8 rising edges; busy falls 32 cycles after LOAD.
// - Back-to-back: push 0x00 then 0xFF in consecutive cycles.
//   - Two frames with no gap; second frame pulse immediately after the 8th falling edge.
//   - Receiver reads 0x00, 0xFF.
// - Overrun: CLK_DIV=4, push 6 samples on consecutive cycles.
//   - Sample 6 sees ready=0 and is dropped; overrun=1.
//   - ARM receives samples 1-5 in order; overrun stays 1 until en=0.
// - Reset mid-word: assert rst during bit 3 of 0xC3.
//   - Next edge: all outputs 0 and FIFO empty.
//   - After release, with no push, the block stays IDLE.
// - Disable: pushes into 0x11,0x22,0x33, then en=0 during word 1.
//   - Word 1 completes; 0x22 and 0x33 are flushed; sample_ready=1.
// - SSP_TX_PARITY_EN: push 0x01 -> 9 rising edges, last bit 1; push 0xA5 -> last bit 0.

Source files
------------

// File: rtl/lo_ssp_tx.sv
// FPGA->ARM SSP sample transmitter: small sample FIFO feeding an MSB-first serialiser.
// Optional `define SSP_TX_PARITY_EN appends an even-parity bit after the LSB (9-bit words).
module lo_ssp_tx #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       pck0,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] sample_in,
   input  logic       sample_valid,
   output logic       sample_ready,
   output logic       ssp_clk,
   output logic       ssp_frame,
   output logic       ssp_din,
   output logic       busy,
   output logic       overrun
);

`ifdef SSP_TX_PARITY_EN
   localparam int unsigned NBITS = 9;
`else
   localparam int unsigned NBITS = 8;
`endif

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [3:0]       BIT_LAST = 4'(NBITS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, count_nxt;
   logic [NBITS-1:0] shift_reg, load_word;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       bit_cnt;
   logic             push, pop, drop, fifo_empty, div_wrap, fall_tick, word_done;

   assign busy = (state != IDLE);

   always_comb begin
      fifo_empty = (count == '0);
      push       = en && sample_valid && sample_ready;
      drop       = en && sample_valid && !sample_ready;
      div_wrap   = (state == SHIFT) && (div_cnt == DIV_LAST);
      fall_tick  = div_wrap && ssp_clk;
      word_done  = fall_tick && (bit_cnt == '0);
`ifdef SSP_TX_PARITY_EN
      load_word  = {mem[rd_ptr], ^mem[rd_ptr]};
`else
      load_word  = mem[rd_ptr];
`endif
      pop        = 1'b0;
      state_nxt  = state;
      unique case (state)
         IDLE: begin
            if (en && !fifo_empty) begin
               pop       = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD:  state_nxt = SHIFT;
         SHIFT: begin
            if (word_done) begin
               if (en && !fifo_empty) pop = 1'b1;
               else                   state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Disabling flushes immediately; the word in flight already lives in shift_reg.
      if (!en) count_nxt = '0;
      else     count_nxt = count + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge pck0) begin
      if (push) mem[wr_ptr] <= sample_in;
   end

   always_ff @(posedge pck0) begin
      if (rst) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         sample_ready <= 1'b1;
         overrun      <= 1'b0;
         shift_reg    <= '0;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         ssp_clk      <= 1'b0;
         ssp_frame    <= 1'b0;
         ssp_din      <= 1'b0;
      end else begin
         state        <= state_nxt;
         count        <= count_nxt;
         sample_ready <= (count_nxt != DEPTH_C);
         if (!en) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
         end else begin
            if (push) wr_ptr  <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr  <= rd_ptr + PTR_W'(1);
            if (drop) overrun <= 1'b1;
         end
         if (pop) shift_reg <= load_word;

         unique case (state)
            IDLE: begin
               ssp_clk   <= 1'b0;
               ssp_frame <= 1'b0;
               ssp_din   <= 1'b0;
               div_cnt   <= '0;
               bit_cnt   <= '0;
            end
            LOAD: begin
               div_cnt   <= '0;
               bit_cnt   <= BIT_LAST;
               ssp_din   <= shift_reg[NBITS-1];
               ssp_frame <= 1'b1;
               ssp_clk   <= 1'b0;
            end
            SHIFT: begin
               if (div_wrap) begin
                  div_cnt <= '0;
                  ssp_clk <= ~ssp_clk;
                  if (fall_tick) begin
                     ssp_frame <= 1'b0;
                     if (word_done) begin
                        // Back-to-back word: first bit and frame go out on this same edge.
                        if (pop) begin
                           ssp_din   <= load_word[NBITS-1];
                           ssp_frame <= 1'b1;
                           bit_cnt   <= BIT_LAST;
                        end else begin
                           ssp_din <= 1'b0;
                        end
                     end else begin
                        bit_cnt   <= bit_cnt - 4'd1;
                        shift_reg <= {shift_reg[NBITS-2:0], 1'b0};
                        ssp_din   <= shift_reg[NBITS-2];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            default: begin
               ssp_clk   <= 1'b0;
               ssp_frame <= 1'b0;
               ssp_din   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lo_ssp_tx.sv
// Directed bench for lo_ssp_tx: table-driven single words plus hand-written
// back-to-back, overrun, reset-abort and disable sequences.
module tb_lo_ssp_tx;

`ifdef SSP_TX_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic       pck0 = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic [7:0] sample_in = '0;
   logic       sample_valid = 1'b0;

   logic ready2, sclk2, frame2, din2, busy2, ovr2;
   logic ready4, sclk4, frame4, din4, busy4, ovr4;

   int errors = 0;
   int checks = 0;

   always #5 pck0 = ~pck0;

   lo_ssp_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) u_dut2 (
      .pck0(pck0), .rst(rst), .en(en), .sample_in(sample_in),
      .sample_valid(sample_valid), .sample_ready(ready2), .ssp_clk(sclk2),
      .ssp_frame(frame2), .ssp_din(din2), .busy(busy2), .overrun(ovr2));

   lo_ssp_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) u_dut4 (
      .pck0(pck0), .rst(rst), .en(en), .sample_in(sample_in),
      .sample_valid(sample_valid), .sample_ready(ready4), .ssp_clk(sclk4),
      .ssp_frame(frame4), .ssp_din(din4), .busy(busy4), .overrun(ovr4));

   // ARM-side receivers: capture ssp_din on each ssp_clk rise, word starts on frame.
   logic       prev2 = 1'b0, prev4 = 1'b0;
   logic [8:0] sh2 = '0, sh4 = '0;
   int         bits2 = 0, bits4 = 0;
   int         rises2 = 0, frames2 = 0, nw2 = 0, nw4 = 0;
   logic [8:0] words2 [64];
   logic [8:0] words4 [64];

   always @(negedge pck0) begin : mon2
      logic [8:0] s;
      int b;
      s = sh2;
      b = bits2;
      if (sclk2 && !prev2) begin
         rises2 <= rises2 + 1;
         if (frame2) begin s = {8'b0, din2}; b = 1; end
         else        begin s = {s[7:0], din2}; b = b + 1; end
         if (b == NB && nw2 < 64) begin words2[nw2] <= s; nw2 <= nw2 + 1; end
      end
      sh2     <= s;
      bits2   <= b;
      frames2 <= frames2 + (frame2 ? 1 : 0);
      prev2   <= sclk2;
   end

   always @(negedge pck0) begin : mon4
      logic [8:0] s;
      int b;
      s = sh4;
      b = bits4;
      if (sclk4 && !prev4) begin
         if (frame4) begin s = {8'b0, din4}; b = 1; end
         else        begin s = {s[7:0], din4}; b = b + 1; end
         if (b == NB && nw4 < 64) begin words4[nw4] <= s; nw4 <= nw4 + 1; end
      end
      sh4   <= s;
      bits4 <= b;
      prev4 <= sclk4;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge pck0);
      #1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
   } vec_t;

   vec_t vec [6];
   logic [7:0] ovr_data [6];
   logic       ovr_rdy  [6];

   function automatic logic [8:0] exp_word(input logic [7:0] d, input logic p);
      return (NB == 9) ? {d, p} : {1'b0, d};
   endfunction

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      int w0, f0, r0;

      vec[0] = '{8'hA5, 1'b0};
      vec[1] = '{8'h00, 1'b0};
      vec[2] = '{8'hFF, 1'b0};
      vec[3] = '{8'h3C, 1'b0};
      vec[4] = '{8'h80, 1'b1};
      vec[5] = '{8'h01, 1'b1};
      ovr_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      ovr_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      // Reset values
      cyc(3);
      check("rst_clk", sclk2, 0);
      check("rst_frame", frame2, 0);
      check("rst_din", din2, 0);
      check("rst_busy", busy2, 0);
      check("rst_ovr", ovr2, 0);
      check("rst_ready", ready2, 1);
      rst = 1'b0;
      cyc(2);

      // Single word 0xA5: latency and framing
      w0 = nw2; f0 = frames2; r0 = rises2;
      sample_in = 8'hA5; sample_valid = 1'b1;
      cyc(1); sample_valid = 1'b0;           // cycle 1
      check("lat_c1_busy", busy2, 0);
      cyc(1);                                // cycle 2 (LOAD)
      check("lat_c2_busy", busy2, 1);
      check("lat_c2_frame", frame2, 0);
      cyc(1);                                // cycle 3
      check("lat_c3_frame", frame2, 1);
      check("lat_c3_din", din2, 1);
      check("lat_c3_clk", sclk2, 0);
      cyc(1);                                // cycle 4
      check("lat_c4_clk", sclk2, 0);
      cyc(1);                                // cycle 5: first rise
      check("lat_c5_clk", sclk2, 1);
      cyc(29);                               // cycle 34
      check("end_c34_busy", busy2, 1);
      cyc(1);                                // cycle 35
      check("end_c35_busy", busy2, 0);
      check("a5_frame_cycles", frames2 - f0, 4);
      check("a5_rises", rises2 - r0, NB);
      check("a5_word", words2[w0], exp_word(8'hA5, 1'b0));
      cyc(3);

      // Table-driven single words
      for (int i = 0; i < 6; i++) begin
         w0 = nw2; f0 = frames2; r0 = rises2;
         sample_in = vec[i].data; sample_valid = 1'b1;
         cyc(1); sample_valid = 1'b0;
         cyc(2 + 4 * NB + 4);
         check("vec_nwords", nw2 - w0, 1);
         check("vec_word", words2[w0], exp_word(vec[i].data, vec[i].par));
         check("vec_frame_cycles", frames2 - f0, 4);
         check("vec_rises", rises2 - r0, NB);
         check("vec_busy", busy2, 0);
      end

      // Back-to-back 0x00, 0xFF
      w0 = nw2; f0 = frames2;
      sample_in = 8'h00; sample_valid = 1'b1;
      cyc(1); sample_in = 8'hFF;
      cyc(1); sample_valid = 1'b0;           // cycle 2
      cyc(4 * NB);                           // last cycle of word 1
      check("b2b_w1end_frame", frame2, 0);
      check("b2b_w1end_clk", sclk2, 1);
      cyc(1);                                // first cycle of word 2
      check("b2b_w2_frame", frame2, 1);
      check("b2b_w2_din", din2, 1);
      check("b2b_w2_busy", busy2, 1);
      cyc(4 * NB + 4);
      check("b2b_nwords", nw2 - w0, 2);
      check("b2b_word0", words2[w0], exp_word(8'h00, 1'b0));
      check("b2b_word1", words2[w0 + 1], exp_word(8'hFF, 1'b0));
      check("b2b_frame_cycles", frames2 - f0, 8);

      // Overrun on the CLK_DIV=4 instance
      rst = 1'b1; cyc(2); rst = 1'b0; cyc(2);
      w0 = nw4;
      for (int i = 0; i < 6; i++) begin
         sample_in = ovr_data[i]; sample_valid = 1'b1;
         check("ovr_ready", ready4, ovr_rdy[i]);
         cyc(1);
      end
      sample_valid = 1'b0;
      check("ovr_set", ovr4, 1);
      cyc(330);
      check("ovr_nwords", nw4 - w0, 5);
      for (int i = 0; i < 5; i++)
         check("ovr_word", words4[w0 + i], exp_word(ovr_data[i], 1'b0));
      check("ovr_sticky", ovr4, 1);
      check("ovr_ready_back", ready4, 1);
      en = 1'b0; cyc(1);
      check("ovr_clear_en0", ovr4, 0);
      en = 1'b1; cyc(2);

      // Reset during bit 3 of 0xC3, with a second word queued
      w0 = nw2;
      sample_in = 8'hC3; sample_valid = 1'b1;
      cyc(1); sample_in = 8'h5A;
      cyc(1); sample_valid = 1'b0;           // cycle 2
      cyc(14);                               // cycle 16: inside bit 3
      check("rmw_busy_before", busy2, 1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("rmw_clk", sclk2, 0);
      check("rmw_frame", frame2, 0);
      check("rmw_din", din2, 0);
      check("rmw_busy", busy2, 0);
      check("rmw_ready", ready2, 1);
      cyc(40);
      check("rmw_idle", busy2, 0);
      check("rmw_nwords", nw2 - w0, 0);

      // Disable during word 1: word completes, queue flushed
      w0 = nw2;
      sample_in = 8'h11; sample_valid = 1'b1;
      cyc(1); sample_in = 8'h22;
      cyc(1); sample_in = 8'h33;
      cyc(1); sample_valid = 1'b0;           // cycle 3
      cyc(2); en = 1'b0;                     // cycle 5
      cyc(4 * NB + 8);
      check("dis_nwords", nw2 - w0, 1);
      check("dis_word", words2[w0], exp_word(8'h11, 1'b0));
      check("dis_ready", ready2, 1);
      check("dis_busy", busy2, 0);
      for (int i = 0; i < 6; i++) begin
         sample_in = 8'h70 + 8'(i); sample_valid = 1'b1;
         cyc(1);
      end
      sample_valid = 1'b0;
      check("dis_no_overrun", ovr2, 0);
      check("dis_ready_en0", ready2, 1);
      en = 1'b1;
      cyc(60);
      check("dis_flushed_nwords", nw2 - w0, 1);
      check("dis_flushed_busy", busy2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
